// File: rtl/h14tx_rst_seq.sv
// rtl/h14tx_rst_seq.sv - HDMI 1.4 TX clocking-chain reset sequencer (PLL, serializer, pixel pipe)
module h14tx_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int SER_GUARD_CYCLES    = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       ser_rst_n,
    output logic       pix_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int MAX_A   = (PLL_RST_CYCLES > SER_GUARD_CYCLES) ? PLL_RST_CYCLES : SER_GUARD_CYCLES;
    localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST  = CW'(SER_GUARD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABILIZE,
        SER_GUARD,
        RUN,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_d, retry_inc;
    logic          lock_meta, lock_s;
    logic          pll_rst_d, ser_rst_n_d, pix_rst_n_d, ready_d, fault_d;

    // Lock is meaningless while the PLL is held in reset, so the synchronizer
    // is flushed then; a stale lock from before the reset can never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (pll_rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            ser_rst_n <= 1'b0;
            pix_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            pll_rst   <= pll_rst_d;
            ser_rst_n <= ser_rst_n_d;
            pix_rst_n <= pix_rst_n_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

    assign retry_inc = (retry_cnt >= RETRY_MAX) ? RETRY_MAX : retry_cnt + 4'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
                end
            end
            STABILIZE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = SER_GUARD;
            end
            SER_GUARD: begin
                if (!lock_s) state_d = PLL_RST;
                else if (cnt_q == GUARD_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s) state_d = PLL_RST;
            end
            FAULT: state_d = FAULT;
            default: state_d = PLL_RST;
        endcase

        if (state_d == RUN && state_q != RUN) retry_d = 4'd0;

        if (soft_rst) begin
            state_d = PLL_RST;
            retry_d = 4'd0;
        end

        // Restarting PllRst via soft_rst also restarts its hold time.
        if (soft_rst || state_d != state_q) cnt_d = '0;
    end

    // Outputs decode the next state so they flip on the same edge as the state.
    always_comb begin
        pll_rst_d   = 1'b0;
        ser_rst_n_d = 1'b0;
        pix_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            PLL_RST:   pll_rst_d = 1'b1;
            SER_GUARD: ser_rst_n_d = 1'b1;
            RUN: begin
                ser_rst_n_d = 1'b1;
                pix_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
